// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared source-ID encodings, size codes and arbiter state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/arb_order_fifo.sv
// ============================================================================
// Module  : arb_order_fifo
// Brief   : 1-bit FIFO recording which source issued each outstanding request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_order_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int C_DEPTH_X = 2
) (
    input  logic clk_i,
    input  logic resetb_i,
    input  logic push_i,
    input  src_e push_id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output src_e head_o
);

    localparam int                 C_DEPTH     = 1 << C_DEPTH_X;
    localparam logic [C_DEPTH_X:0] C_DEPTH_CNT = (C_DEPTH_X+1)'(C_DEPTH);

    src_e                 r_mem [C_DEPTH];
    logic [C_DEPTH_X-1:0] r_wptr;
    logic [C_DEPTH_X-1:0] r_rptr;
    logic [C_DEPTH_X:0]   r_count;

    // Callers only push when not full and pop when not empty.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + 1'b1;
            if (pop_i)  r_rptr <= r_rptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= push_id_i;
    end

    assign full_o  = (r_count == C_DEPTH_CNT);
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-source (I/D) arbiter onto one in-order memory port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int C_OT_DEPTH_X = 2
) (
    input  logic        clk_i,
    input  logic        clk_en_i,
    input  logic        resetb_i,
    input  logic        ireqvalid_i,
    output logic        ireqready_o,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    output logic        irspvalid_o,
    input  logic        irspready_i,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,
    input  logic        dreqvalid_i,
    output logic        dreqready_o,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqwrite_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    output logic        drspvalid_o,
    input  logic        drspready_i,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,
    output logic        mreqvalid_o,
    input  logic        mreqready_i,
    output logic [1:0]  mreqsize_o,
    output logic        mreqwrite_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,
    input  logic        mrspvalid_i,
    output logic        mrspready_o,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    arb_state_e r_state, w_state_nxt;
    src_e       r_lock_sel, w_lock_sel_nxt;
    src_e       r_last_won, w_last_won_nxt;
    src_e       w_sel;
    src_e       w_head;
    logic       w_src_valid;
    logic       w_full, w_empty;
    logic       w_active;
    logic       w_mreq_hs, w_mrsp_hs;

    // Reset is folded in so every handshake output reads 0 while held in reset.
    assign w_active = clk_en_i & resetb_i;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state    <= ST_UNLOCKED;
            r_lock_sel <= SRC_I;
            r_last_won <= SRC_D;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
            r_last_won <= w_last_won_nxt;
        end
    end

    always_comb begin
        w_sel          = SRC_I;
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        w_last_won_nxt = r_last_won;

        if (r_state == ST_LOCKED) begin
            w_sel = r_lock_sel;
        end else if (ireqvalid_i && dreqvalid_i) begin
            w_sel = (r_last_won == SRC_I) ? SRC_D : SRC_I;
        end else if (dreqvalid_i) begin
            w_sel = SRC_D;
        end

        w_src_valid = (w_sel == SRC_D) ? dreqvalid_i : ireqvalid_i;
        mreqvalid_o = w_src_valid & ~w_full & w_active;
        ireqready_o = (w_sel == SRC_I) & mreqready_i & ~w_full & w_active;
        dreqready_o = (w_sel == SRC_D) & mreqready_i & ~w_full & w_active;
        w_mreq_hs   = mreqvalid_o & mreqready_i;

        if (w_mreq_hs) begin
            w_state_nxt    = ST_UNLOCKED;
            w_last_won_nxt = w_sel;
        end else if (mreqvalid_o && r_state == ST_UNLOCKED) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_sel_nxt = w_sel;
        end

        if (w_sel == SRC_D) begin
            mreqsize_o  = dreqsize_i;
            mreqwrite_o = dreqwrite_i;
            mreqhpl_o   = dreqhpl_i;
            mreqaddr_o  = dreqaddr_i;
            mreqdata_o  = dreqdata_i;
        end else begin
            mreqsize_o  = C_SIZE_WORD;
            mreqwrite_o = 1'b0;
            mreqhpl_o   = ireqhpl_i;
            mreqaddr_o  = ireqaddr_i;
            mreqdata_o  = '0;
        end
    end

    // Responses follow the FIFO head; with nothing outstanding they stall.
    assign irspvalid_o = ~w_empty & (w_head == SRC_I) & mrspvalid_i & w_active;
    assign drspvalid_o = ~w_empty & (w_head == SRC_D) & mrspvalid_i & w_active;
    assign mrspready_o = ~w_empty & w_active &
                         ((w_head == SRC_D) ? drspready_i : irspready_i);
    assign w_mrsp_hs   = mrspvalid_i & mrspready_o;

    assign irsprerr_o = mrsprerr_i;
    assign irspdata_o = mrspdata_i;
    assign drsprerr_o = mrsprerr_i;
    assign drspwerr_o = mrspwerr_i;
    assign drspdata_o = mrspdata_i;

    arb_order_fifo #(
        .C_DEPTH_X (C_OT_DEPTH_X)
    ) u_order_fifo (
        .clk_i     (clk_i),
        .resetb_i  (resetb_i),
        .push_i    (w_mreq_hs),
        .push_id_i (w_sel),
        .pop_i     (w_mrsp_hs),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .head_o    (w_head)
    );

endmodule

`default_nettype wire
